// File: rtl/seq_booth_mult_pkg.sv
// ============================================================================
// Module : seq_mult_pkg
// Brief  : Shared types and helpers for the sequential Booth multiplier family
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_mult_pkg;

  // Controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Radix-2 Booth recoding of one multiplier bit pair
  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Iteration counter width: must hold WIDTH+1
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  // {Q[0],Q-1} -> operation applied to the accumulator
  function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_booth_mult_booth_step.sv
// ============================================================================
// Module : booth_step
// Brief  : One combinational radix-2 Booth iteration: conditional add/sub of
//          the extended multiplicand, then arithmetic shift of {A,Q,Q-1}
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_a,
  input  logic [WIDTH:0]   i_q,
  input  logic             i_qm1,
  input  logic [WIDTH:0]   i_mcand,
  output logic [WIDTH+1:0] o_a,
  output logic [WIDTH:0]   o_q,
  output logic             o_qm1
);

  // Multiplicand is already WIDTH+1 bits two's complement; one more sign bit
  // lets the accumulator absorb subtraction of the most negative value.
  logic [WIDTH+1:0] w_mcand_sx;
  logic [WIDTH+1:0] w_sum;

  assign w_mcand_sx = {i_mcand[WIDTH], i_mcand};

  // Add/sub selected by the Booth pair, then shift right keeping A's sign
  always_comb begin
    w_sum = i_a;
    case (booth_decode(i_q[0], i_qm1))
      OP_ADD:  w_sum = i_a + w_mcand_sx;
      OP_SUB:  w_sum = i_a - w_mcand_sx;
      default: w_sum = i_a;
    endcase
    {o_a, o_q, o_qm1} = {w_sum[WIDTH+1], w_sum, i_q};
  end

endmodule

`default_nettype wire

// File: rtl/seq_booth_mult.sv
// ============================================================================
// Module : seq_booth_mult
// Brief  : WIDTH x WIDTH sequential radix-2 Booth multiplier, one iteration
//          per clock, signed/unsigned per operation, busy/done handshake
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_booth_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 St,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     Mplier,
  input  logic [WIDTH-1:0]     Mcand,
  output logic [2*WIDTH-1:0]   Prod,
  output logic                 busy,
  output logic                 done
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH + 1);

  state_e               state_q, state_d;
  logic [WIDTH+1:0]     a_q, a_d;
  logic [WIDTH:0]       q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH:0]       mcand_q, mcand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH+1:0]     step_a;
  logic [WIDTH:0]       step_q;
  logic                 step_qm1;

  // Extending by one bit makes both modes a plain (WIDTH+1)-bit signed multiply
  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] v, input logic s);
    return {s & v[WIDTH-1], v};
  endfunction

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a     (a_q),
    .i_q     (q_q),
    .i_qm1   (qm1_q),
    .i_mcand (mcand_q),
    .o_a     (step_a),
    .o_q     (step_q),
    .o_qm1   (step_qm1)
  );

  // Next-state logic: load in IDLE, iterate in CALC, publish result from DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (St) begin
          mcand_d = extend(Mcand, sgn);
          q_d     = extend(Mplier, sgn);
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = step_a;
        q_d   = step_q;
        qm1_d = step_qm1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Low 2*WIDTH bits of {A,Q} are the exact product in either mode
        prod_d  = {a_q[WIDTH-2:0], q_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Prod = prod_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_booth_mult.sv
// ============================================================================
// Module : tb_seq_booth_mult
// Brief  : Self-checking bench for seq_booth_mult at WIDTH = 4, 8 and 16
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_booth_mult;

  logic        clk;
  logic        rst_n;
  logic        st_a   [3];
  logic        sgn_a  [3];
  logic [31:0] mpl    [3];
  logic [31:0] mc     [3];

  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic        busy4, busy8, busy16;
  logic        done4, done8, done16;

  int passed = 0;
  int total  = 0;

  seq_booth_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .St(st_a[0]), .sgn(sgn_a[0]),
    .Mplier(mpl[0][3:0]), .Mcand(mc[0][3:0]),
    .Prod(prod4), .busy(busy4), .done(done4)
  );

  seq_booth_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .St(st_a[1]), .sgn(sgn_a[1]),
    .Mplier(mpl[1][7:0]), .Mcand(mc[1][7:0]),
    .Prod(prod8), .busy(busy8), .done(done8)
  );

  seq_booth_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .St(st_a[2]), .sgn(sgn_a[2]),
    .Mplier(mpl[2][15:0]), .Mcand(mc[2][15:0]),
    .Prod(prod16), .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int i);
    logic [63:0] r;
    r = '0;
    case (i)
      0:       r[7:0]  = prod4;
      1:       r[15:0] = prod8;
      default: r[31:0] = prod16;
    endcase
    return r;
  endfunction

  function automatic logic get_done(input int i);
    case (i)
      0:       return done4;
      1:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int i);
    case (i)
      0:       return busy4;
      1:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [63:0] mask2(input int w);
    return (64'd1 << (2 * w)) - 64'd1;
  endfunction

  // Reference: interpret operands per mode, multiply as integers, keep 2W bits
  function automatic logic [63:0] ref_prod(input int w, input bit s,
                                           input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'(a & ((32'd1 << w) - 32'd1));
    y = longint'(b & ((32'd1 << w) - 32'd1));
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    return logic'(1) ? (64'(x * y) & mask2(w)) : 64'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One operation; caller must be between clock edges. Returns result,
  // edges from acceptance to done (64 = never seen), and busy coverage.
  task automatic run_op(input int i, input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat, output bit busy_ok);
    int n;
    sgn_a[i] = s;
    mpl[i]   = a;
    mc[i]    = b;
    st_a[i]  = 1'b1;
    @(posedge clk);
    #1;
    st_a[i]  = 1'b0;
    mpl[i]   = $urandom;
    mc[i]    = $urandom;
    sgn_a[i] = ~s;
    busy_ok  = get_busy(i);
    n = 0;
    while (n < 64) begin
      @(posedge clk);
      #1;
      n++;
      if (get_done(i)) break;
      if (!get_busy(i)) busy_ok = 1'b0;
    end
    p   = get_prod(i);
    lat = n;
  endtask

  typedef struct {
    int     idx;
    bit     sgn;
    int     a;
    int     b;
    longint exp;
  } vec_t;

  vec_t vecs[10];

  task automatic rand_run(input int i);
    logic [63:0] p;
    int          lat;
    bit          bok;
    bit          s;
    logic [31:0] a, b;
    int          w;
    w = width_of(i);
    for (int n = 0; n < 2000; n++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'd1 << (w - 1);
      if ($urandom_range(0, 9) == 0) b = 32'd1 << (w - 1);
      run_op(i, s, a, b, p, lat, bok);
      check($sformatf("rand_w%0d_s%0d_%0h_%0h", w, s, a, b), p, ref_prod(w, s, a, b));
      check($sformatf("rand_lat_w%0d", w), 64'(lat), 64'(w + 2));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [63:0] p;
    int          lat;
    int          cnt;
    bit          bok;

    vecs[0] = '{0, 1'b1,    3,   -4,    -12};
    vecs[1] = '{0, 1'b1,   -5,    7,    -35};
    vecs[2] = '{0, 1'b1,   -8,   -3,     24};
    vecs[3] = '{0, 1'b1,    7,   -7,    -49};
    vecs[4] = '{0, 1'b1,   -8,   -8,     64};
    vecs[5] = '{1, 1'b0,  255,  255,  65025};
    vecs[6] = '{1, 1'b0,    0,  200,      0};
    vecs[7] = '{1, 1'b1, -128, -128,  16384};
    vecs[8] = '{1, 1'b1, -128,  127, -16256};
    vecs[9] = '{1, 1'b1,    1,   -1,     -1};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_a[i] = 1'b0; sgn_a[i] = 1'b0; mpl[i] = '0; mc[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_prod_%0d", i), get_prod(i), 64'd0);
      check($sformatf("reset_busy_%0d", i), 64'(get_busy(i)), 64'd0);
      check($sformatf("reset_done_%0d", i), 64'(get_done(i)), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].idx, vecs[v].sgn, 32'(vecs[v].a), 32'(vecs[v].b), p, lat, bok);
      check($sformatf("vec%0d_prod", v), p, 64'(vecs[v].exp) & mask2(width_of(vecs[v].idx)));
      check($sformatf("vec%0d_lat", v), 64'(lat), 64'(width_of(vecs[v].idx) + 2));
      check($sformatf("vec%0d_busy", v), 64'(bok), 64'd1);
      @(negedge clk);
    end

    // St held through the whole op with operands changing after acceptance
    sgn_a[0] = 1'b1; mpl[0] = 32'd3; mc[0] = 32'hFFFF_FFFC; st_a[0] = 1'b1;
    @(posedge clk);
    #1;
    mpl[0] = 32'd5; mc[0] = 32'd6; sgn_a[0] = 1'b0;
    bok = busy4;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (done4) break;
      if (!busy4) bok = 1'b0;
    end
    st_a[0] = 1'b0;
    check("held_st_lat", 64'(lat), 64'd6);
    check("held_st_prod", 64'(prod4), 64'hF4);
    check("held_st_busy", 64'(bok), 64'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done4), 64'd0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done4) cnt++;
    end
    check("held_st_single_op", 64'(cnt), 64'd0);

    // Back-to-back: second St issued in the done cycle
    run_op(1, 1'b1, 32'd100, 32'hFFFF_FFFD, p, lat, bok);
    check("b2b_first_prod", p, 64'hFED4);
    run_op(1, 1'b0, 32'd200, 32'd3, p, lat, bok);
    check("b2b_second_prod", p, 64'd600);
    check("b2b_second_lat", 64'(lat), 64'd10);

    // Reset during CALC, after the third iteration
    @(negedge clk);
    sgn_a[1] = 1'b1; mpl[1] = 32'd100; mc[1] = 32'hFFFF_FFFD; st_a[1] = 1'b1;
    @(posedge clk);
    #1;
    st_a[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_prod", 64'(prod8), 64'd0);
    check("rst_mid_busy", 64'(busy8), 64'd0);
    check("rst_mid_done", 64'(done8), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done8) cnt++;
    end
    check("rst_no_done", 64'(cnt), 64'd0);
    run_op(1, 1'b1, 32'hFFFF_FF81, 32'd2, p, lat, bok);
    check("rst_fresh_prod", p, 64'hFF02);
    check("rst_fresh_lat", 64'(lat), 64'd10);

    // Random traffic on all three widths concurrently
    @(negedge clk);
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
